// File: rtl/ballot_pkg.sv
// ----------------------------------------------------------------------------
// ballot_pkg
//  Shared definitions for the ballot collector front-end:
//   - voter count (tied to the 4-bit voter_switch.I input)
//   - default debounce / session timeout constants
//   - session state type and its fixed encoding
//   - small helper for the "everyone has voted" test
// ----------------------------------------------------------------------------
package ballot_pkg;

    localparam int N_VOTERS                = 4;
    localparam int DEFAULT_DEBOUNCE_CYCLES = 4;
    localparam int DEFAULT_TIMEOUT_CYCLES  = 1000;

    // Encoding is fixed; 2'b11 is unused and recovers to IDLE.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_OPEN = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    function automatic logic all_voted(input logic [N_VOTERS-1:0] mask);
        return &mask;
    endfunction

endpackage

// File: rtl/switch_debounce.sv
// ----------------------------------------------------------------------------
// switch_debounce
//  Conditions one raw, asynchronous switch bit.
//  A 2-flop synchroniser feeds a stability counter; the debounced level only
//  follows the synchronised input after DEBOUNCE_CYCLES consecutive cycles of
//  disagreement, and any bounce back restarts the count. A registered pulse
//  marks each 0->1 change of the debounced level, asserted in the same cycle
//  the new level becomes visible.
//
// Ports
//  clk    in   1  system clock, rising edge
//  rst_n  in   1  asynchronous active-low reset
//  raw    in   1  raw switch input (asynchronous)
//  level  out  1  debounced level
//  rise   out  1  one-cycle pulse on debounced 0->1
// ----------------------------------------------------------------------------
module switch_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level,
    output logic rise
);

    // Sized to hold DEBOUNCE_CYCLES-1 even when DEBOUNCE_CYCLES is 1.
    localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_reg;
    logic             sync2_reg;
    logic             level_reg;
    logic             level_next;
    logic             rise_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;

    // The count tracks how many consecutive cycles the synced input has
    // disagreed with the debounced level; agreement clears it.
    always_comb begin
        level_next = level_reg;
        cnt_next   = '0;
        if (sync2_reg != level_reg) begin
            if (cnt_reg == CNT_LAST) begin
                level_next = sync2_reg;
            end else begin
                cnt_next = cnt_reg + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_reg <= 1'b0;
            sync2_reg <= 1'b0;
            level_reg <= 1'b0;
            cnt_reg   <= '0;
            rise_reg  <= 1'b0;
        end else begin
            sync1_reg <= raw;
            sync2_reg <= sync1_reg;
            level_reg <= level_next;
            cnt_reg   <= cnt_next;
            rise_reg  <= level_next & ~level_reg;
        end
    end

    assign level = level_reg;
    assign rise  = rise_reg;

endmodule

// File: rtl/ballot_collector.sv
// ----------------------------------------------------------------------------
// ballot_collector
//  Voting machine front-end. Debounces each voter's cast pushbutton and yes/no
//  switch, runs one session per start pulse, latches one vote per voter and
//  presents the frozen ballot word until the consumer acknowledges it.
//
// Ports
//  clk           in   1         system clock, rising edge
//  rst_n         in   1         asynchronous active-low reset
//  start         in   1         opens a session when IDLE
//  ack           in   1         consumer took the ballot; DONE -> IDLE
//  sw_cast       in   N_VOTERS  raw cast pushbuttons, active-high
//  sw_yes        in   N_VOTERS  raw yes(1)/no(0) switches
//  ballot        out  N_VOTERS  latched votes (non-voters read as no)
//  voted         out  N_VOTERS  voter i has cast this session
//  ballot_valid  out  1         high while in DONE
//  timed_out     out  1         session closed by timeout
//  busy          out  1         state != IDLE
// ----------------------------------------------------------------------------
module ballot_collector
    import ballot_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int TIMEOUT_CYCLES  = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                ack,
    input  logic [N_VOTERS-1:0] sw_cast,
    input  logic [N_VOTERS-1:0] sw_yes,
    output logic [N_VOTERS-1:0] ballot,
    output logic [N_VOTERS-1:0] voted,
    output logic                ballot_valid,
    output logic                timed_out,
    output logic                busy
);

    localparam int            TW         = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

    // ------------------------------------------------------------------
    // Input conditioning
    // ------------------------------------------------------------------
    logic [N_VOTERS-1:0] cast_level;
    logic [N_VOTERS-1:0] cast_rise;
    logic [N_VOTERS-1:0] yes_level;
    // Yes switches are sampled as levels; their rise pulses have no consumer.
    logic [N_VOTERS-1:0] unused_yes_rise;

    genvar gi;
    generate
        for (gi = 0; gi < N_VOTERS; gi++) begin : g_voter
            switch_debounce #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_cast_db (
                .clk   (clk),
                .rst_n (rst_n),
                .raw   (sw_cast[gi]),
                .level (cast_level[gi]),
                .rise  (cast_rise[gi])
            );

            switch_debounce #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_yes_db (
                .clk   (clk),
                .rst_n (rst_n),
                .raw   (sw_yes[gi]),
                .level (yes_level[gi]),
                .rise  (unused_yes_rise[gi])
            );
        end
    endgenerate

    // Only the edge of the cast button matters; holding it has no effect.
    logic [N_VOTERS-1:0] unused_cast_level;
    assign unused_cast_level = cast_level;

    // ------------------------------------------------------------------
    // Session FSM, timer and ballot registers
    // ------------------------------------------------------------------
    state_t              state_reg,     state_next;
    logic [TW-1:0]       timer_reg,     timer_next;
    logic [N_VOTERS-1:0] ballot_reg,    ballot_next;
    logic [N_VOTERS-1:0] voted_reg,     voted_next;
    logic                timed_out_reg, timed_out_next;
    logic [N_VOTERS-1:0] accept;

    // A cast counts only once per voter per session.
    assign accept = cast_rise & ~voted_reg;

    always_comb begin
        state_next     = state_reg;
        timer_next     = timer_reg;
        ballot_next    = ballot_reg;
        voted_next     = voted_reg;
        timed_out_next = timed_out_reg;

        unique case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    state_next     = ST_OPEN;
                    timer_next     = '0;
                    ballot_next    = '0;
                    voted_next     = '0;
                    timed_out_next = 1'b0;
                end
            end

            ST_OPEN: begin
                timer_next  = timer_reg + TW'(1);
                ballot_next = (ballot_reg & ~accept) | (yes_level & accept);
                voted_next  = voted_reg | accept;
                // Casts landing on the timeout cycle still count, and a full
                // ballot on that same cycle is reported as a normal close.
                if (all_voted(voted_next)) begin
                    state_next     = ST_DONE;
                    timed_out_next = 1'b0;
                end else if (timer_reg == TIMER_LAST) begin
                    state_next     = ST_DONE;
                    timed_out_next = 1'b1;
                end
            end

            ST_DONE: begin
                // A start arriving with ack only closes; a fresh start is needed.
                if (ack) begin
                    state_next = ST_IDLE;
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            timer_reg     <= '0;
            ballot_reg    <= '0;
            voted_reg     <= '0;
            timed_out_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            timer_reg     <= timer_next;
            ballot_reg    <= ballot_next;
            voted_reg     <= voted_next;
            timed_out_reg <= timed_out_next;
        end
    end

    assign ballot       = ballot_reg;
    assign voted        = voted_reg;
    assign timed_out    = timed_out_reg;
    assign ballot_valid = (state_reg == ST_DONE);
    assign busy         = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_ballot_collector.sv
module tb_ballot_collector;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       ack;
    logic [3:0] sw_cast;
    logic [3:0] sw_yes;
    logic [3:0] ballot;
    logic [3:0] voted;
    logic       ballot_valid;
    logic       timed_out;
    logic       busy;

    int total = 0;
    int bad   = 0;

    ballot_collector #(
        .DEBOUNCE_CYCLES(4),
        .TIMEOUT_CYCLES (64)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .ack          (ack),
        .sw_cast      (sw_cast),
        .sw_yes       (sw_yes),
        .ballot       (ballot),
        .voted        (voted),
        .ballot_valid (ballot_valid),
        .timed_out    (timed_out),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled on the falling edge.
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; ack = 1'b0; sw_cast = '0; sw_yes = '0;
        tick(3);
        rst_n = 1'b1;
        tick(2);
        total++;
        if ({ballot, voted, ballot_valid, timed_out, busy} !== 11'd0) begin
            bad++;
            $display("FAIL reset_outputs: got ballot=%b voted=%b valid=%b to=%b busy=%b, want all 0",
                     ballot, voted, ballot_valid, timed_out, busy);
        end
        $display("test_reset: ballot=%b voted=%b busy=%b", ballot, voted, busy);
    endtask

    task automatic test_sequential_votes();
        logic [3:0] want;
        sw_yes = 4'b1010;
        tick(10);
        pulse_start();
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL seq_busy: got %b want 1", busy);
        end
        for (int i = 0; i < 4; i++) begin
            sw_cast[i] = 1'b1;
            tick(14);
            want = 4'((1 << (i + 1)) - 1);
            total++;
            if (voted !== want) begin
                bad++;
                $display("FAIL seq_voted_%0d: got %b want %b", i, voted, want);
            end
        end
        total++;
        if ({ballot, voted, ballot_valid, timed_out} !== {4'b1010, 4'b1111, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL seq_done: got ballot=%b voted=%b valid=%b to=%b, want 1010 1111 1 0",
                     ballot, voted, ballot_valid, timed_out);
        end
        ack = 1'b1;
        tick(1);
        ack = 1'b0;
        total++;
        if ({busy, ballot_valid, ballot, voted} !== {1'b0, 1'b0, 4'b1010, 4'b1111}) begin
            bad++;
            $display("FAIL seq_ack: got busy=%b valid=%b ballot=%b voted=%b, want 0 0 1010 1111",
                     busy, ballot_valid, ballot, voted);
        end
        sw_cast = '0;
        tick(10);
        $display("test_sequential_votes: ballot=%b voted=%b", ballot, voted);
    endtask

    task automatic test_bounce();
        bit seen;
        sw_yes = 4'b0000;
        tick(10);
        pulse_start();
        sw_cast[2] = 1'b1; tick(1);
        sw_cast[2] = 1'b0; tick(1);
        sw_cast[2] = 1'b1;              // last edge
        tick(6);
        total++;
        if (voted !== 4'b0000) begin
            bad++;
            $display("FAIL bounce_early: got voted=%b want 0000 six clocks after last edge", voted);
        end
        tick(1);
        total++;
        if ({voted, ballot} !== {4'b0100, 4'b0000}) begin
            bad++;
            $display("FAIL bounce_accept: got voted=%b ballot=%b want 0100 0000", voted, ballot);
        end
        // Repeat press with the switch now on yes must not change the vote.
        sw_yes = 4'b0100;
        sw_cast[2] = 1'b0; tick(10);
        sw_cast[2] = 1'b1; tick(10);
        total++;
        if ({voted, ballot} !== {4'b0100, 4'b0000}) begin
            bad++;
            $display("FAIL bounce_repeat: got voted=%b ballot=%b want 0100 0000", voted, ballot);
        end
        seen = 1'b0;
        for (int i = 0; i < 80 && !seen; i++) begin
            tick(1);
            seen = ballot_valid;
        end
        total++;
        if (!seen || {timed_out, ballot, voted} !== {1'b1, 4'b0000, 4'b0100}) begin
            bad++;
            $display("FAIL bounce_close: got valid=%b to=%b ballot=%b voted=%b want 1 1 0000 0100",
                     seen, timed_out, ballot, voted);
        end
        ack = 1'b1; tick(1); ack = 1'b0;
        sw_cast = '0;
        tick(10);
        $display("test_bounce: ballot=%b voted=%b", ballot, voted);
    endtask

    task automatic test_timeout();
        sw_yes = 4'b1111;
        tick(10);
        pulse_start();                  // start edge S has passed
        sw_cast = 4'b0110;
        tick(10);                       // S+10
        total++;
        if (voted !== 4'b0110) begin
            bad++;
            $display("FAIL to_partial: got voted=%b want 0110", voted);
        end
        sw_cast = '0;
        tick(53);                       // S+63: timer reached 63, still open
        total++;
        if (ballot_valid !== 1'b0) begin
            bad++;
            $display("FAIL to_early: got valid=%b want 0 before timer 63 edge", ballot_valid);
        end
        tick(1);                        // S+64
        total++;
        if ({ballot_valid, timed_out, ballot, voted} !== {1'b1, 1'b1, 4'b0110, 4'b0110}) begin
            bad++;
            $display("FAIL to_done: got valid=%b to=%b ballot=%b voted=%b want 1 1 0110 0110",
                     ballot_valid, timed_out, ballot, voted);
        end
        pulse_start();
        total++;
        if (ballot_valid !== 1'b1) begin
            bad++;
            $display("FAIL done_start_ignored: got valid=%b want 1", ballot_valid);
        end
        start = 1'b1; ack = 1'b1;
        tick(1);
        start = 1'b0; ack = 1'b0;
        tick(3);
        total++;
        if ({busy, ballot_valid} !== 2'b00) begin
            bad++;
            $display("FAIL start_ack_idle: got busy=%b valid=%b want 0 0", busy, ballot_valid);
        end
        $display("test_timeout: ballot=%b voted=%b timed_out=%b", ballot, voted, timed_out);
    endtask

    task automatic test_simultaneous();
        sw_yes = 4'b0101;
        tick(10);
        pulse_start();
        sw_cast = 4'b1111;
        tick(6);
        total++;
        if ({ballot_valid, voted} !== {1'b0, 4'b0000}) begin
            bad++;
            $display("FAIL sim_early: got valid=%b voted=%b want 0 0000", ballot_valid, voted);
        end
        tick(1);
        total++;
        if ({ballot_valid, timed_out, ballot, voted} !== {1'b1, 1'b0, 4'b0101, 4'b1111}) begin
            bad++;
            $display("FAIL sim_done: got valid=%b to=%b ballot=%b voted=%b want 1 0 0101 1111",
                     ballot_valid, timed_out, ballot, voted);
        end
        ack = 1'b1; tick(1); ack = 1'b0;
        sw_cast = '0;
        tick(10);
        $display("test_simultaneous: ballot=%b voted=%b", ballot, voted);
    endtask

    task automatic test_midsession_reset();
        sw_yes = 4'b0011;
        tick(10);
        pulse_start();
        sw_cast = 4'b0011;
        tick(8);
        total++;
        if ({busy, voted, ballot} !== {1'b1, 4'b0011, 4'b0011}) begin
            bad++;
            $display("FAIL mid_votes: got busy=%b voted=%b ballot=%b want 1 0011 0011",
                     busy, voted, ballot);
        end
        #1 rst_n = 1'b0;
        #1;
        total++;
        if ({ballot, voted, ballot_valid, timed_out, busy} !== 11'd0) begin
            bad++;
            $display("FAIL mid_async_reset: got ballot=%b voted=%b valid=%b to=%b busy=%b want all 0",
                     ballot, voted, ballot_valid, timed_out, busy);
        end
        tick(2);
        rst_n = 1'b1;
        // Cast buttons are still held, so they re-rise while IDLE.
        tick(12);
        total++;
        if ({busy, voted} !== {1'b0, 4'b0000}) begin
            bad++;
            $display("FAIL idle_cast_ignored: got busy=%b voted=%b want 0 0000", busy, voted);
        end
        pulse_start();
        tick(10);
        total++;
        if ({busy, voted} !== {1'b1, 4'b0000}) begin
            bad++;
            $display("FAIL held_cast_no_vote: got busy=%b voted=%b want 1 0000", busy, voted);
        end
        $display("test_midsession_reset: ballot=%b voted=%b", ballot, voted);
    endtask

    initial begin
        test_reset();
        test_sequential_votes();
        test_bounce();
        test_timeout();
        test_simultaneous();
        test_midsession_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
